// File: rtl/led_blink_ctrl_pkg.sv
// Shared types and constants for the status-LED sequencing controller.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSolid,
        StBlinkOn,
        StBlinkOff,
        StBurstOn,
        StBurstOff
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    function automatic logic led_of(state_t s);
        return s inside {StSolid, StBlinkOn, StBurstOn};
    endfunction

    function automatic logic busy_of(state_t s);
        return s inside {StBurstOn, StBurstOff};
    endfunction

    // States whose duration is set by the prescaler.
    function automatic logic timed_of(state_t s);
        return s inside {StBlinkOn, StBlinkOff, StBurstOn, StBurstOff};
    endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Control/status bundle between the switch decode logic and the LED controller.
interface led_blink_if;
    logic       en;
    logic [1:0] mode;
    logic [3:0] burst_len;
    logic       start;
    logic       led;
    logic       busy;
    logic       done;

    modport master (
        output en, mode, burst_len, start,
        input  led, busy, done
    );

    modport slave (
        input  en, mode, burst_len, start,
        output led, busy, done
    );
endinterface

// File: rtl/led_blink_ctrl_prescaler.sv
// Phase timer: flags the last cycle of each HALF_PERIOD-long on/off phase.
module blink_prescaler #(
    parameter int unsigned HALF_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic phase_end
);
    localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || !run) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign phase_end = run && (cnt_q == CNT_W'(HALF_PERIOD - 1));
endmodule

// File: rtl/led_blink_ctrl.sv
// Status-LED sequencer: off, solid, continuous blink or a counted burst of blinks.
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    led_blink_if.slave  bus
);
    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic       led_q, busy_q, done_q, done_d;
    logic       phase_end;
    logic       clr;

    blink_prescaler #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .run       (timed_of(state_q)),
        .phase_end (phase_end)
    );

    // Restart phase timing on every state change.
    assign clr = (state_d != state_q);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (!bus.en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mode == MODE_SOLID) begin
                        state_d = StSolid;
                    end else if (bus.mode == MODE_BLINK) begin
                        state_d = StBlinkOn;
                    end else if (bus.mode == MODE_BURST && bus.start && bus.burst_len != 4'd0) begin
                        state_d     = StBurstOn;
                        remaining_d = bus.burst_len;
                    end
                end
                StSolid: begin
                    if (bus.mode != MODE_SOLID) state_d = StIdle;
                end
                StBlinkOn: begin
                    if (bus.mode != MODE_BLINK) state_d = StIdle;
                    else if (phase_end)         state_d = StBlinkOff;
                end
                StBlinkOff: begin
                    if (bus.mode != MODE_BLINK) state_d = StIdle;
                    else if (phase_end)         state_d = StBlinkOn;
                end
                StBurstOn: begin
                    if (phase_end) state_d = StBurstOff;
                end
                StBurstOff: begin
                    if (phase_end) begin
                        if (remaining_q == 4'd1) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            remaining_d = remaining_q - 4'd1;
                            state_d     = StBurstOn;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered alongside the state, so they always match its decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            remaining_q <= 4'd0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            led_q       <= led_of(state_d);
            busy_q      <= busy_of(state_d);
            done_q      <= done_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Sequencing controller for the board status LED on the lab FPGA. It takes the enable, mode and burst controls derived from the DIP switches and drives one LED as off, solid on, continuous blink, or a counted burst of blinks. A prescaler counter sets the on/off timing: at the default parameter value on the 48 MHz clock, continuous blink runs at 2.4 Hz. It sits beside the switch-to-LED decode logic and owns the time-varying LED output.

Parameters:
HALF_PERIOD, 10_000_000, clk cycles per on-phase and per off-phase (48e6/(2*2.4)); must be >= 2; benches override to 4
CNT_W, $clog2(HALF_PERIOD), prescaler counter width (derived)

Ports:
clk  input  1  system clock (48 MHz HSOSC)
reset  input  1  synchronous, active-low reset
en  input  1  global enable; 0 forces IDLE
mode  input  2  00 off, 01 solid, 10 continuous blink, 11 burst
burst_len  input  4  number of blinks per burst (1..15)
start  input  1  burst trigger, sampled in IDLE with mode=11
led  output  1  LED drive, active-high
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse at normal burst completion

Behaviour:
- Reset: reset=0 at a clk edge -> state IDLE, cnt=0, remaining=0, led=0, busy=0, done=0. Reset has priority over every other input and applies mid-burst.
- States: IDLE, SOLID, BLINK_ON, BLINK_OFF, BURST_ON, BURST_OFF.
- led and busy are Moore outputs decoded from the state register, with no combinational path from inputs:
  - led=1 in SOLID, BLINK_ON and BURST_ON.
  - busy=1 in BURST_ON and BURST_OFF.
- done is a registered output. It is high for exactly the first cycle the FSM is in IDLE after a normal burst completion.
- Prescaler:
  - cnt clears to 0 on every state change and counts while in any ON/OFF state.
  - phase_end = (cnt == HALF_PERIOD-1).
  - Each ON/OFF state therefore lasts exactly HALF_PERIOD cycles.
- Transitions (priority: reset > en=0 > rules below):
  - Any state, en=0 -> IDLE next edge. A burst aborted this way gives no done pulse.
  - IDLE:
    - mode=01 -> SOLID.
    - mode=10 -> BLINK_ON.
    - mode=11 & start & burst_len!=0 -> BURST_ON, remaining<=burst_len.
    - mode=11 & start & burst_len=0 -> stay IDLE, no done.
  - SOLID: mode!=01 -> IDLE.
  - BLINK_ON / BLINK_OFF:
    - mode!=10 -> IDLE.
    - Otherwise, phase_end toggles between BLINK_ON and BLINK_OFF.
  - BURST_ON: phase_end -> BURST_OFF.
  - BURST_OFF, on phase_end:
    - remaining==1 -> IDLE, done pulse.
    - Otherwise remaining<=remaining-1, -> BURST_ON.
- During a burst, mode, start and burst_len are ignored. The burst always runs to completion unless en=0 or reset=0.
- Latency: a request seen at edge k gives the new state, and the new led value, from edge k+1.
- Blink cycle timing:
  - Continuous-blink period = 2*HALF_PERIOD.
  - A burst of N blinks keeps busy high for exactly 2*N*HALF_PERIOD cycles.
- A simultaneous start and mode change in IDLE uses the mode sampled that cycle.
- remaining is 4 bits wide and never wraps, because 0 is never loaded.

Decomposition:
- Package led_ctrl_pkg holds:
  - the state enum (state_t, 3-bit);
  - the mode constants MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BURST (2-bit).
- Sub-module blink_prescaler (param HALF_PERIOD):
  - inputs: clk, reset, clr, run;
  - output: phase_end.
  - Instantiated once by led_blink_ctrl.

Test Plan:
1. HALF_PERIOD=4. Assert en=1, mode=11, burst_len=3, pulse start; hold reset=0 for 2 cycles at cycle 5 -> led=0, busy=0, done=0 during and after reset. Release reset -> FSM in IDLE and no burst resumes.
2. en=1, mode=01 -> led=1 from the next edge. Then mode=00 -> led=0 on the following edge. en=0 while mode=01 -> led=0 next edge.
3. mode=10 for 24 cycles -> led pattern 1111 0000 repeated 3 times, starting one cycle after mode is applied. Then mode=00 mid-ON-phase -> led=0 next edge.
4. mode=11, burst_len=3, 1-cycle start pulse ->
   - exactly 3 led high pulses of 4 cycles, separated by 4 low cycles;
   - busy high for 24 cycles;
   - done high for exactly 1 cycle after the final off-phase;
   - led=0 afterwards.
5. During the burst in scenario 4:
   - extra start pulses and mode=10 have no effect; same 24-cycle result.
   - A repeat run with en=0 during the 2nd ON phase -> led=0, busy=0 next edge, done never asserts.
6. mode=11, burst_len=0, start pulse -> led, busy and done stay 0 for 20 cycles.
